// File: rtl/ins_fetch.sv
// Front-end fetch stage.
// Requests 32-bit words from the icache at the current pc and splits them into RV32I or RV32C
// instructions. Direct jumps are resolved locally. Conditional branches are predicted with a
// table of 2-bit saturating counters. The stage hands one instruction at a time to the decoder,
// and ROB flushes redirect it.
module ins_fetch #(
    parameter int unsigned          RAM_ADR_W = 32,
    parameter logic [RAM_ADR_W-1:0] RST_PC    = '0,
    parameter int unsigned          BHT_BIT   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    // icache
    output logic                 ic_req_o,
    output logic [RAM_ADR_W-1:0] ic_adr_o,
    input  logic                 ic_rdy_i,
    input  logic [31:0]          ic_dat_i,
    // backpressure and redirect
    input  logic                 dc_full_i,
    input  logic                 rob_flush_i,
    input  logic [RAM_ADR_W-1:0] rob_pc_i,
    input  logic                 rob_upd_i,
    input  logic [RAM_ADR_W-1:0] rob_upd_pc_i,
    input  logic                 rob_tk_i,
    // decoder
    output logic                 dec_en_o,
    output logic                 dec_ic_o,
    output logic [31:0]          dec_ins_o,
    output logic [RAM_ADR_W-1:0] dec_pc_o,
    output logic                 dec_pbr_o
);

    localparam int BhtN = 1 << BHT_BIT;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [RAM_ADR_W-1:0] pc_q, pc_d;
    logic                 req_q, req_d;
    logic [RAM_ADR_W-1:0] adr_q, adr_d;
    logic [RAM_ADR_W-1:0] nxt_q, nxt_d;
    logic                 dic_q, dic_d;
    logic [31:0]          dins_q, dins_d;
    logic [RAM_ADR_W-1:0] dpc_q, dpc_d;
    logic                 dpbr_q, dpbr_d;
    logic [1:0]           bht_q [BhtN];
    logic [1:0]           bht_d [BhtN];
    logic                 dec_en;

    // Only the index bits of the committed-branch pc address the table.
    logic unused_upd_pc;
    assign unused_upd_pc = ^{rob_upd_pc_i[RAM_ADR_W-1:BHT_BIT+1], rob_upd_pc_i[0]};

    // ------------------------------------------------------------------
    // Predecode of the word arriving from the icache.
    // ------------------------------------------------------------------
    logic        is_c;
    logic [6:0]  opc;
    logic [2:0]  c_f3;
    logic        c_q01;
    logic        is_jal, is_br, is_cj, is_cb;
    logic [31:0] imm_j, imm_b, imm_cj, imm_cb;
    logic [31:0] pc_w;
    logic [31:0] tgt_off;
    logic [31:0] nxt_sum;
    logic        pred_tk;
    logic [BHT_BIT-1:0] idx_f, idx_u;

    assign is_c   = (ic_dat_i[1:0] != 2'b11);
    assign opc    = ic_dat_i[6:0];
    assign c_f3   = ic_dat_i[15:13];
    assign c_q01  = (ic_dat_i[1:0] == 2'b01);
    assign is_jal = !is_c && (opc == 7'b1101111);
    assign is_br  = !is_c && (opc == 7'b1100011);
    assign is_cj  = c_q01 && ((c_f3 == 3'b101) || (c_f3 == 3'b001));
    assign is_cb  = c_q01 && ((c_f3 == 3'b110) || (c_f3 == 3'b111));

    assign imm_j  = {{11{ic_dat_i[31]}}, ic_dat_i[31], ic_dat_i[19:12], ic_dat_i[20],
                     ic_dat_i[30:21], 1'b0};
    assign imm_b  = {{19{ic_dat_i[31]}}, ic_dat_i[31], ic_dat_i[7], ic_dat_i[30:25],
                     ic_dat_i[11:8], 1'b0};
    assign imm_cj = {{20{ic_dat_i[12]}}, ic_dat_i[12], ic_dat_i[8], ic_dat_i[10:9],
                     ic_dat_i[6], ic_dat_i[7], ic_dat_i[2], ic_dat_i[11], ic_dat_i[5:3], 1'b0};
    assign imm_cb = {{23{ic_dat_i[12]}}, ic_dat_i[12], ic_dat_i[6:5], ic_dat_i[2],
                     ic_dat_i[11:10], ic_dat_i[4:3], 1'b0};

    assign pc_w  = 32'(pc_q);
    assign idx_f = pc_q[BHT_BIT:1];
    assign idx_u = rob_upd_pc_i[BHT_BIT:1];

    // Select the pc offset of the following instruction and the prediction bit.
    always_comb begin
        pred_tk = 1'b0;
        tgt_off = is_c ? 32'd2 : 32'd4;
        if (is_jal) begin
            tgt_off = imm_j;
        end else if (is_cj) begin
            tgt_off = imm_cj;
        end else if (is_br || is_cb) begin
            // Reads the table before any same-cycle commit update.
            pred_tk = bht_q[idx_f][1];
            if (pred_tk) begin
                tgt_off = is_br ? imm_b : imm_cb;
            end
        end
        nxt_sum = pc_w + tgt_off;
    end

    // ------------------------------------------------------------------
    // Next-state logic: FSM, pc, request, latched decode and BHT.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        adr_d   = adr_q;
        nxt_d   = nxt_q;
        dic_d   = dic_q;
        dins_d  = dins_q;
        dpc_d   = dpc_q;
        dpbr_d  = dpbr_q;
        bht_d   = bht_q;
        dec_en  = 1'b0;

        if (en) begin
            // Commit updates apply even while a flush is in progress.
            if (rob_upd_i) begin
                if (rob_tk_i) begin
                    if (bht_q[idx_u] != 2'b11) begin
                        bht_d[idx_u] = bht_q[idx_u] + 2'd1;
                    end
                end else if (bht_q[idx_u] != 2'b00) begin
                    bht_d[idx_u] = bht_q[idx_u] - 2'd1;
                end
            end

            if (rob_flush_i) begin
                pc_d = rob_pc_i;
                case (state_q)
                    S_WAIT: begin
                        // An outstanding response must still be swallowed.
                        if (ic_rdy_i) begin
                            req_d   = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            state_d = S_DROP;
                        end
                    end
                    S_DROP: begin
                        if (ic_rdy_i) begin
                            req_d   = 1'b0;
                            state_d = S_REQ;
                        end
                    end
                    default: state_d = S_REQ;
                endcase
            end else begin
                case (state_q)
                    S_REQ: begin
                        req_d   = 1'b1;
                        adr_d   = pc_q;
                        state_d = S_WAIT;
                    end
                    S_WAIT: begin
                        if (ic_rdy_i) begin
                            req_d   = 1'b0;
                            dic_d   = is_c;
                            dins_d  = is_c ? {16'h0000, ic_dat_i[15:0]} : ic_dat_i;
                            dpc_d   = pc_q;
                            dpbr_d  = pred_tk;
                            nxt_d   = nxt_sum[RAM_ADR_W-1:0];
                            state_d = S_OUT;
                        end
                    end
                    S_OUT: begin
                        if (!dc_full_i) begin
                            dec_en  = 1'b1;
                            pc_d    = nxt_q;
                            state_d = S_REQ;
                        end
                    end
                    default: begin
                        if (ic_rdy_i) begin
                            req_d   = 1'b0;
                            state_d = S_REQ;
                        end
                    end
                endcase
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RST_PC;
            req_q   <= 1'b0;
            adr_q   <= '0;
            nxt_q   <= '0;
            dic_q   <= 1'b0;
            dins_q  <= '0;
            dpc_q   <= '0;
            dpbr_q  <= 1'b0;
            for (int i = 0; i < BhtN; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            adr_q   <= adr_d;
            nxt_q   <= nxt_d;
            dic_q   <= dic_d;
            dins_q  <= dins_d;
            dpc_q   <= dpc_d;
            dpbr_q  <= dpbr_d;
            bht_q   <= bht_d;
        end
    end

    assign ic_req_o  = req_q;
    assign ic_adr_o  = adr_q;
    assign dec_en_o  = dec_en;
    assign dec_ic_o  = dic_q;
    assign dec_ins_o = dins_q;
    assign dec_pc_o  = dpc_q;
    assign dec_pbr_o = dpbr_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed scenarios followed by random fetches checked against a
// reference model built from instruction-field arithmetic and a counter table.
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        ic_req_o, ic_rdy_i;
    logic [31:0] ic_adr_o, ic_dat_i;
    logic        dc_full_i, rob_flush_i, rob_upd_i, rob_tk_i;
    logic [31:0] rob_pc_i, rob_upd_pc_i;
    logic        dec_en_o, dec_ic_o, dec_pbr_o;
    logic [31:0] dec_ins_o, dec_pc_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          bht [64];
    logic [31:0] mdl_pc;

    ins_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ic_req_o    (ic_req_o),
        .ic_adr_o    (ic_adr_o),
        .ic_rdy_i    (ic_rdy_i),
        .ic_dat_i    (ic_dat_i),
        .dc_full_i   (dc_full_i),
        .rob_flush_i (rob_flush_i),
        .rob_pc_i    (rob_pc_i),
        .rob_upd_i   (rob_upd_i),
        .rob_upd_pc_i(rob_upd_pc_i),
        .rob_tk_i    (rob_tk_i),
        .dec_en_o    (dec_en_o),
        .dec_ic_o    (dec_ic_o),
        .dec_ins_o   (dec_ins_o),
        .dec_pc_o    (dec_pc_o),
        .dec_pbr_o   (dec_pbr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] fld(input logic [31:0] w, input int hi, input int lo);
        return (w >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] sx(input logic [31:0] v, input int n);
        if (((v >> (n - 1)) & 32'd1) != 0) return v - (32'd1 << n);
        return v;
    endfunction

    function automatic int bidx(input logic [31:0] pc);
        return int'((pc >> 1) & 32'd63);
    endfunction

    // What the decoder should see for word w fetched at pc, given the counter value.
    function automatic void model(input logic [31:0] pc, input logic [31:0] w, input int ctr,
                                  output logic c, output logic [31:0] ins,
                                  output logic pbr, output logic [31:0] nxt);
        logic [31:0] off;
        logic [31:0] f3;
        c   = (w & 32'd3) != 32'd3;
        ins = c ? (w & 32'h0000FFFF) : w;
        pbr = 1'b0;
        nxt = pc + (c ? 32'd2 : 32'd4);
        f3  = fld(w, 15, 13);
        if (!c && fld(w, 6, 0) == 32'h6F) begin
            off = (fld(w, 31, 31) << 20) | (fld(w, 19, 12) << 12) | (fld(w, 20, 20) << 11)
                | (fld(w, 30, 21) << 1);
            nxt = pc + sx(off, 21);
        end else if (!c && fld(w, 6, 0) == 32'h63) begin
            pbr = ctr >= 2;
            off = (fld(w, 31, 31) << 12) | (fld(w, 7, 7) << 11) | (fld(w, 30, 25) << 5)
                | (fld(w, 11, 8) << 1);
            if (pbr) nxt = pc + sx(off, 13);
        end else if (fld(w, 1, 0) == 32'd1 && (f3 == 32'd5 || f3 == 32'd1)) begin
            off = (fld(w, 12, 12) << 11) | (fld(w, 8, 8) << 10) | (fld(w, 10, 9) << 8)
                | (fld(w, 6, 6) << 7) | (fld(w, 7, 7) << 6) | (fld(w, 2, 2) << 5)
                | (fld(w, 11, 11) << 4) | (fld(w, 5, 3) << 1);
            nxt = pc + sx(off, 12);
        end else if (fld(w, 1, 0) == 32'd1 && (f3 == 32'd6 || f3 == 32'd7)) begin
            pbr = ctr >= 2;
            off = (fld(w, 12, 12) << 8) | (fld(w, 6, 5) << 6) | (fld(w, 2, 2) << 5)
                | (fld(w, 11, 10) << 3) | (fld(w, 4, 3) << 1);
            if (pbr) nxt = pc + sx(off, 9);
        end
    endfunction

    function automatic void model_upd(input logic [31:0] pc, input logic tk);
        int i;
        i = bidx(pc);
        if (tk) bht[i] = (bht[i] == 3) ? 3 : bht[i] + 1;
        else    bht[i] = (bht[i] == 0) ? 0 : bht[i] - 1;
    endfunction

    task automatic upd(input logic [31:0] pc, input logic tk);
        rob_upd_i    = 1'b1;
        rob_upd_pc_i = pc;
        rob_tk_i     = tk;
        model_upd(pc, tk);
        step();
        rob_upd_i = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (ic_req_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"}, ic_req_o, 1'b1);
    endtask

    // One complete fetch: request, response after dly cycles, optional backpressure and
    // frozen cycles, then issue. An optional commit update lands in the response cycle.
    task automatic do_fetch(input string tag, input logic [31:0] w, input int dly,
                            input int full, input int off,
                            input logic u, input logic [31:0] u_pc, input logic u_tk);
        logic        e_c, e_pbr;
        logic [31:0] e_ins, e_nxt;
        wait_req(tag);
        chk({tag, "_adr"}, ic_adr_o, mdl_pc);
        repeat (dly) step();
        model(mdl_pc, w, bht[bidx(mdl_pc)], e_c, e_ins, e_pbr, e_nxt);
        dc_full_i = (full > 0);
        ic_rdy_i  = 1'b1;
        ic_dat_i  = w;
        if (u) begin
            rob_upd_i    = 1'b1;
            rob_upd_pc_i = u_pc;
            rob_tk_i     = u_tk;
            model_upd(u_pc, u_tk);
        end
        step();
        ic_rdy_i  = 1'b0;
        ic_dat_i  = $urandom;
        rob_upd_i = 1'b0;
        for (int i = 0; i < full; i++) begin
            chk({tag, "_full_en"}, dec_en_o, 1'b0);
            chk({tag, "_full_req"}, ic_req_o, 1'b0);
            step();
        end
        dc_full_i = 1'b0;
        for (int i = 0; i < off; i++) begin
            en           = 1'b0;
            rob_flush_i  = 1'b1;
            rob_pc_i     = 32'hDEAD_BEE0;
            rob_upd_i    = 1'b1;
            rob_upd_pc_i = mdl_pc;
            rob_tk_i     = 1'b1;
            #1;
            chk({tag, "_frz_en"}, dec_en_o, 1'b0);
            step();
        end
        en          = 1'b1;
        rob_flush_i = 1'b0;
        rob_upd_i   = 1'b0;
        #1;
        chk({tag, "_en"}, dec_en_o, 1'b1);
        chk({tag, "_ic"}, dec_ic_o, e_c);
        chk({tag, "_ins"}, dec_ins_o, e_ins);
        chk({tag, "_pc"}, dec_pc_o, mdl_pc);
        chk({tag, "_pbr"}, dec_pbr_o, e_pbr);
        mdl_pc = e_nxt;
        step();
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom % 6)
            0: ;
            1: w = (w & ~32'h7F) | 32'h6F;
            2: w = (w & ~32'h7F) | 32'h63;
            3: w = (w & ~32'hE003) | 32'h1 | (($urandom % 2) != 0 ? 32'hA000 : 32'h2000);
            4: w = (w & ~32'hE003) | 32'h1 | (($urandom % 2) != 0 ? 32'hC000 : 32'hE000);
            default: w[1:0] = 2'($urandom % 3);
        endcase
        return w;
    endfunction

    initial begin
        rst          = 1'b1;
        en           = 1'b1;
        ic_rdy_i     = 1'b0;
        ic_dat_i     = '0;
        dc_full_i    = 1'b0;
        rob_flush_i  = 1'b0;
        rob_pc_i     = '0;
        rob_upd_i    = 1'b0;
        rob_upd_pc_i = '0;
        rob_tk_i     = 1'b0;
        for (int i = 0; i < 64; i++) bht[i] = 1;
        mdl_pc = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req", ic_req_o, 1'b0);
        chk("rst_adr", ic_adr_o, 32'h0);
        chk("rst_en", dec_en_o, 1'b0);
        chk("rst_ins", dec_ins_o, 32'h0);
        chk("rst_pbr", dec_pbr_o, 1'b0);

        // Straight-line code, compressed code and a direct jump.
        do_fetch("addi", 32'h0050_0093, 1, 0, 0, 1'b0, 0, 1'b0);
        do_fetch("cli", 32'h0001_4505, 0, 0, 0, 1'b0, 0, 1'b0);
        do_fetch("cnop", 32'h0000_0001, 2, 0, 0, 1'b0, 0, 1'b0);
        do_fetch("jal16", 32'h0100_006F, 0, 0, 0, 1'b0, 0, 1'b0);
        chk("jal16_tgt", mdl_pc, 32'h18);
        do_fetch("jal8", 32'h0080_006F, 1, 0, 0, 1'b0, 0, 1'b0);

        // Train the counter at 0x20 then fetch a backward beq there.
        repeat (4) upd(32'h20, 1'b1);
        do_fetch("beq", 32'hFE00_0CE3, 0, 0, 0, 1'b0, 0, 1'b0);
        chk("beq_tgt", mdl_pc, 32'h18);

        // Flush while the request is outstanding; the late response must be dropped.
        wait_req("flush");
        rob_flush_i = 1'b1;
        rob_pc_i    = 32'h100;
        #1;
        chk("flush_en0", dec_en_o, 1'b0);
        step();
        rob_flush_i = 1'b0;
        chk("flush_drop_req", ic_req_o, 1'b1);
        chk("flush_en1", dec_en_o, 1'b0);
        step();
        ic_rdy_i = 1'b1;
        ic_dat_i = 32'h0000_0013;
        #1;
        chk("flush_en2", dec_en_o, 1'b0);
        step();
        ic_rdy_i = 1'b0;
        chk("flush_en3", dec_en_o, 1'b0);
        mdl_pc = 32'h100;
        do_fetch("redir", 32'h0000_0013, 0, 0, 0, 1'b0, 0, 1'b0);

        // Backpressure, then a frozen stage ignoring flush and update.
        do_fetch("full", 32'h0010_0113, 0, 5, 0, 1'b0, 0, 1'b0);
        do_fetch("frz", 32'h0000_C001, 1, 0, 3, 1'b0, 0, 1'b0);

        // Same-cycle update and lookup: the lookup sees the weak not-taken value.
        upd(mdl_pc, 1'b0);
        upd(mdl_pc, 1'b0);
        upd(mdl_pc, 1'b1);
        do_fetch("samecyc", 32'hFE00_0CE3, 0, 0, 0, 1'b1, mdl_pc, 1'b1);

        for (int k = 0; k < 60; k++) begin
            int nu;
            nu = $urandom % 4;
            for (int j = 0; j < nu; j++) upd(mdl_pc, 1'($urandom % 2));
            do_fetch("rnd", rnd_word(), $urandom % 4, $urandom % 3, $urandom % 2,
                     1'b0, 0, 1'b0);
        end

        // Reset mid-fetch restores pc and the weak not-taken table.
        upd(32'h0, 1'b1);
        upd(32'h0, 1'b1);
        wait_req("mrst");
        rst = 1'b1;
        #1;
        chk("mrst_req", ic_req_o, 1'b0);
        chk("mrst_en", dec_en_o, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) bht[i] = 1;
        mdl_pc = 32'h0;
        do_fetch("postrst", 32'hFE00_0CE3, 0, 0, 0, 1'b0, 0, 1'b0);
        chk("postrst_nxt", mdl_pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
